// File: rtl/msg_tx_sequencer.sv
// msg_tx_sequencer
//   Walks the message ROM from address 0 to MSG_LEN-1 and hands each byte to
//   the UART transmitter using its new_data/busy/block handshake. One message
//   is sent per start request.
//
// Optional build macro: MSG_TX_AUTO_REPEAT_EN
//   When defined, the block re-sends the message automatically after an idle
//   gap of REPEAT_CYCLES clocks following each completed message.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request one message (sampled only in IDLE)
//   rom_addr     ROM address (registered)
//   rom_data     ROM read data, valid one clock after rom_addr changes
//   tx_data      byte to UART (registered, holds the last byte sent)
//   tx_new_data  one-cycle strobe, tx_data valid
//   tx_busy      UART is shifting a byte
//   tx_block     downstream flow control, no new byte while high
//   busy         high from the first FETCH through the last GAP
//   done         one-cycle pulse when the message completes
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start (or the auto-repeat timer)
// FETCH  | rom_addr stable, ROM registers the byte at the end of cycle
// SEND   | rom_data valid, wait for tx_busy and tx_block both low
// STROBE | tx_new_data high for this single cycle
// GAP    | tx_busy ignored (UART busy rise latency), advance or finish
module msg_tx_sequencer #(
    parameter int MSG_LEN       = 23,
    parameter int ADDR_W        = 5,
    parameter int REPEAT_CYCLES = 50000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        tx_data,
    output logic              tx_new_data,
    input  logic              tx_busy,
    input  logic              tx_block,
    output logic              busy,
    output logic              done
);

    if (MSG_LEN < 1 || MSG_LEN > (1 << ADDR_W) || REPEAT_CYCLES < 1) begin : g_param_check
        $error("msg_tx_sequencer: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_STROBE,
        ST_GAP
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_new_data_q, tx_new_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              go;

`ifdef MSG_TX_AUTO_REPEAT_EN
    localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_LOAD = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    // Armed only after a completed message, so reset never triggers a re-send.
    logic             rpt_armed_q, rpt_armed_d;
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        rom_addr_d    = rom_addr_q;
        tx_data_d     = tx_data_q;
        tx_new_data_d = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        go            = 1'b0;
`ifdef MSG_TX_AUTO_REPEAT_EN
        rpt_cnt_d     = rpt_cnt_q;
        rpt_armed_d   = rpt_armed_q;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef MSG_TX_AUTO_REPEAT_EN
                if (start) begin
                    go          = 1'b1;
                    rpt_armed_d = 1'b0;
                    rpt_cnt_d   = '0;
                end else if (rpt_armed_q) begin
                    if (rpt_cnt_q == '0) begin
                        go          = 1'b1;
                        rpt_armed_d = 1'b0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q - 1'b1;
                    end
                end
`else
                go = start;
`endif
                if (go) begin
                    idx_d      = '0;
                    rom_addr_d = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_FETCH;
                end
            end

            ST_FETCH: begin
                state_d = ST_SEND;
            end

            ST_SEND: begin
                if (!tx_busy && !tx_block) begin
                    tx_data_d     = rom_data;
                    tx_new_data_d = 1'b1;
                    state_d       = ST_STROBE;
                end
            end

            ST_STROBE: begin
                state_d = ST_GAP;
            end

            ST_GAP: begin
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
`ifdef MSG_TX_AUTO_REPEAT_EN
                    rpt_cnt_d   = RPT_LOAD;
                    rpt_armed_d = 1'b1;
`endif
                end else begin
                    idx_d      = idx_q + 1'b1;
                    rom_addr_d = idx_q + 1'b1;
                    state_d    = ST_FETCH;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            rom_addr_q    <= '0;
            tx_data_q     <= 8'h00;
            tx_new_data_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef MSG_TX_AUTO_REPEAT_EN
            rpt_cnt_q     <= '0;
            rpt_armed_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            rom_addr_q    <= rom_addr_d;
            tx_data_q     <= tx_data_d;
            tx_new_data_q <= tx_new_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
`ifdef MSG_TX_AUTO_REPEAT_EN
            rpt_cnt_q     <= rpt_cnt_d;
            rpt_armed_q   <= rpt_armed_d;
`endif
        end
    end

    assign rom_addr    = rom_addr_q;
    assign tx_data     = tx_data_q;
    assign tx_new_data = tx_new_data_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
